// File: rtl/ftdi_uart_rx.sv
// FTDI async-serial receiver: 2-flop synchronizer, mid-bit sampling FSM,
// first-word-fall-through receive FIFO and registered RTS# flow control.
module ftdi_uart_rx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_MARGIN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rts_n,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun
);
    localparam int CNT_W    = $clog2(CLK_DIV);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int OCC_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] RTS_LVL   = OCC_W'(FIFO_DEPTH - RTS_MARGIN);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_e;

    logic             rx_meta_q, rx_meta_d;
    logic             rxs_q, rxs_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             rts_n_q, rts_n_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic push, pop, full, wr_en;

    // Receive framing
    always_comb begin
        rx_meta_d = rxd;
        rxs_d     = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = BIT_LOAD;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    cnt_d   = BIT_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs_q) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                // A held-low line must not look like a fresh start bit.
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a pop frees the slot a same-cycle push needs
    always_comb begin
        rx_valid = (count_q != '0);
        full     = (count_q == FULL_CNT);
        pop      = rx_valid & rx_ready;
        wr_en    = push & (~full | pop);
        ov_d     = push & full & ~pop;
        wptr_d   = wr_en ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d   = pop ? rptr_q + PTR_W'(1) : rptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + OCC_W'(1);
        else if (!wr_en && pop) count_d = count_q - OCC_W'(1);
        rts_n_d  = (count_d >= RTS_LVL);
        rx_data  = rx_valid ? mem_q[rptr_q] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shreg_q   <= 8'h00;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            rts_n_q   <= 1'b1;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
            rts_n_q   <= rts_n_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[wptr_q] <= shreg_q;
    end

    assign rts_n       = rts_n_q;
    assign frame_error = fe_q;
    assign overrun     = ov_q;

endmodule

// File: tb/tb_ftdi_uart_rx.sv
// Bench for ftdi_uart_rx: timestamp-based line/FIFO model checked every cycle,
// plus directed frames with literal expectations.
module tb_ftdi_uart_rx;
    localparam int D      = 16;
    localparam int H      = D / 2;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rts_n, rx_valid, frame_error, overrun;
    logic [7:0] rx_data;

    ftdi_uart_rx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rts_n(rts_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_error(frame_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: line seen two edges late; a frame starting at edge t0 samples
    // at t0 + H + k*D (k=1..8 data, k=9 stop).
    logic [7:0] q[$];
    logic       sy1 = 1'b1, sy2 = 1'b1;
    int         t0 = -1;
    bit         recov = 1'b0;
    logic [7:0] bits = 8'h00;
    logic       e_fe = 1'b0, e_ov = 1'b0, e_rts = 1'b1, in_rst = 1'b1;

    always @(posedge clk) begin
        logic s;
        bit   do_push, do_pop;
        int   off, k;
        cyc++;
        s   = sy2;
        sy2 = sy1;
        sy1 = rxd;
        if (reset) begin
            q.delete();
            t0 = -1; recov = 1'b0;
            e_fe = 1'b0; e_ov = 1'b0; e_rts = 1'b1; in_rst = 1'b1;
            sy1 = 1'b1; sy2 = 1'b1;
        end else begin
            in_rst  = 1'b0;
            e_fe    = 1'b0;
            e_ov    = 1'b0;
            do_push = 1'b0;
            do_pop  = (q.size() != 0) && rx_ready;
            if (recov) begin
                if (s) recov = 1'b0;
            end else if (t0 < 0) begin
                if (!s) t0 = cyc;
            end else begin
                off = cyc - t0 - H;
                if (off == 0 && s) t0 = -1;
                else if (off > 0 && off % D == 0) begin
                    k = off / D;
                    if (k <= 8) bits[k-1] = s;
                    else begin
                        t0 = -1;
                        if (s) do_push = 1'b1;
                        else begin e_fe = 1'b1; recov = 1'b1; end
                    end
                end
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) q.push_back(bits);
                else e_ov = 1'b1;
            end
            e_rts = (q.size() >= DEPTH - MARGIN);
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("rx_valid", rx_valid, q.size() != 0);
            if (q.size() != 0) chk("rx_data", rx_data, q[0]);
            else if (in_rst)   chk("rx_data_rst", rx_data, 0);
            chk("rts_n", rts_n, e_rts);
            chk("frame_error", frame_error, e_fe);
            chk("overrun", overrun, e_ov);
        end
    end

    // Observed-event counters for the literal checks
    int         nrise = 0, vcyc = 0, fe_cnt = 0, ov_cnt = 0, rise_cyc = 0;
    logic [7:0] rise_data = 8'h00;
    logic       pv = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !pv) begin nrise++; rise_cyc = cyc; rise_data = rx_data; end
        if (rx_valid) vcyc++;
        if (frame_error) fe_cnt++;
        if (overrun) ov_cnt++;
        pv = rx_valid;
    end

    task automatic clr_cnt();
        nrise = 0; vcyc = 0; fe_cnt = 0; ov_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int last_start = 0;
    // One frame; stop bit held low for low_stop bit-times, then idle high.
    // rdy_at >= 0 pulses rx_ready for the single edge following that offset.
    task automatic send(input logic [7:0] b, input int low_stop, input int rdy_at);
        int n, j;
        n = (9 + low_stop) * D + D + 4;
        @(posedge clk); #1;
        last_start = cyc;
        for (int i = 0; i < n; i++) begin
            j = i / D;
            if (j == 0)                rxd = 1'b0;
            else if (j <= 8)           rxd = b[j-1];
            else if (j < 9 + low_stop) rxd = 1'b0;
            else                       rxd = 1'b1;
            if (rdy_at >= 0) rx_ready = (i == rdy_at);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input logic [7:0] exp);
        chk("drain", {rx_valid, rx_data}, {1'b1, exp});
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        // Reset state
        step(1);
        chk("rst_rts_n", rts_n, 1);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        step(2);
        reset = 1'b0;
        step(1);
        chk("rts_after_rst", rts_n, 0);
        step(5);

        // 0xA5, good stop, consumer always ready
        rx_ready = 1'b1;
        clr_cnt();
        send(8'hA5, 0, -1);
        step(4);
        chk("a5_latency", rise_cyc - last_start, 3 + H + 9 * D);
        chk("a5_data", rise_data, 8'hA5);
        chk("a5_valid_cycles", vcyc, 1);
        chk("a5_pulses", fe_cnt + ov_cnt, 0);

        // 5-cycle glitch, then 0x3C
        clr_cnt();
        rxd = 1'b0;
        step(5);
        rxd = 1'b1;
        step(20);
        chk("glitch_no_push", nrise, 0);
        send(8'h3C, 0, -1);
        step(4);
        chk("3c_count", nrise, 1);
        chk("3c_data", rise_data, 8'h3C);

        // Stop bit low for 20 bit-times, then 0x01
        clr_cnt();
        send(8'h55, 20, -1);
        chk("fe_count", fe_cnt, 1);
        chk("fe_no_push", nrise, 0);
        send(8'h01, 0, -1);
        step(4);
        chk("01_count", nrise, 1);
        chk("01_data", rise_data, 8'h01);

        // Fill to overrun with rx_ready low
        rx_ready = 1'b0;
        clr_cnt();
        for (int i = 0; i <= 16; i++) begin
            b = 8'(i);
            send(b, 0, -1);
            if (i == 10) chk("rts_11_bytes", rts_n, 0);
            if (i == 11) chk("rts_12_bytes", rts_n, 1);
        end
        chk("overrun_count", ov_cnt, 1);
        chk("fill_fe", fe_cnt, 0);
        for (int i = 0; i < 16; i++) drain(8'(i));
        chk("drained_empty", rx_valid, 0);

        // Full FIFO, pop on the stop-sample edge of 0x77
        clr_cnt();
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 0, -1);
        chk("full_rts", rts_n, 1);
        send(8'h77, 0, 2 + H + 9 * D);
        chk("full_pop_no_ov", ov_cnt, 0);
        for (int i = 1; i < 16; i++) drain(8'(8'h20 + i));
        drain(8'h77);
        chk("full_pop_empty", rx_valid, 0);

        // Reset during data bit 4 with 3 bytes buffered
        send(8'h11, 0, -1);
        send(8'h22, 0, -1);
        send(8'h33, 0, -1);
        clr_cnt();
        b = 8'hA5;
        for (int i = 0; i < 5 * D + 8; i++) begin
            rxd = (i / D == 0) ? 1'b0 : b[i / D - 1];
            @(posedge clk); #1;
        end
        reset = 1'b1;
        step(1);
        chk("midrst_rts_n", rts_n, 1);
        chk("midrst_valid", rx_valid, 0);
        step(2);
        rxd = 1'b1;
        reset = 1'b0;
        step(1);
        chk("midrst_rts_release", rts_n, 0);
        step(3 * D);
        chk("midrst_no_fe", fe_cnt, 0);
        chk("midrst_no_ov", ov_cnt, 0);
        chk("midrst_no_data", nrise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ftdi_uart_rx.md
FTDI_UART_RX -- requirements
Module: ftdi_uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning clocks per UART bit (minimum 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, at least 4).
REQ-003 SHALL have parameter RTS_MARGIN, default 4, meaning free entries remaining at which RTS# is deasserted.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rxd  input  1  FTDI BD0 serial data, asynchronous, idle high.
REQ-007 SHALL have port rts_n  output  1  FTDI BD3 RTS#; 0 means the FPGA can accept data.
REQ-008 SHALL have port rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
REQ-009 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts the head byte.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse when a bad stop bit is detected.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass rxd through a two-flop synchronizer; the FSM uses only the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP and RECOVER, and a bit-timing counter of width clog2(CLK_DIV).
REQ-015 In IDLE, on rxs=0, SHALL enter START and load the counter with CLK_DIV/2-1 (integer division).
REQ-016 In START, at counter 0, SHALL enter DATA and load CLK_DIV-1 if rxs=0; if rxs=1 (glitch), SHALL return to IDLE with no output.
REQ-017 In DATA, at each counter 0, SHALL shift rxs into the data register LSB first and reload CLK_DIV-1; after the 8th sample it SHALL enter STOP.
REQ-018 In STOP, at counter 0 with rxs=1, SHALL push the byte and enter IDLE in the same cycle.
REQ-019 In STOP, at counter 0 with rxs=0, SHALL pulse frame_error, discard the byte, and enter RECOVER.
REQ-020 In RECOVER, SHALL stay until rxs=1, then enter IDLE; no start detection is allowed while in RECOVER.
REQ-021 Bit samples SHALL be taken mid-bit, i.e. CLK_DIV/2 + k*CLK_DIV cycles after the synchronized falling edge, for k = 1..9.
REQ-022 FIFO SHALL be first-word-fall-through: rx_data = head entry; a pop occurs when rx_valid and rx_ready are both 1 in the same cycle.
REQ-023 A push when the FIFO is full and no pop occurs SHALL drop the byte and pulse overrun; FIFO contents SHALL be unchanged.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when full (no overrun) and when count=1 (rx_valid stays 1).
REQ-025 A push into an empty FIFO SHALL raise rx_valid on the next cycle, so latency from the stop-bit sample to rx_valid is 1 cycle.
REQ-026 rx_ready while rx_valid=0 SHALL have no effect.
REQ-027 The occupancy counter SHALL be clog2(FIFO_DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 rts_n SHALL be a registered output equal to (count >= FIFO_DEPTH-RTS_MARGIN), evaluated from the post-update count.
REQ-029 frame_error and overrun SHALL be high for exactly one cycle per event and can never both be high in the same cycle.

Reset
REQ-030 While reset=1, SHALL force: FSM=IDLE, counter=0, both synchronizer flops=1, FIFO empty (pointers and count 0), rx_valid=0, frame_error=0, overrun=0, rts_n=1.
REQ-031 rx_data SHALL be 0 in reset and is otherwise don't-care while rx_valid=0.
REQ-032 rts_n SHALL go to 0 on the first cycle after reset is released.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no push and no pulse; after release, a line still low SHALL be treated as a new start bit.

Verification
REQ-034 CLK_DIV=16: send 0xA5 with a good stop bit, rx_ready=1 -> rx_valid=1 with rx_data=0xA5 for 1 cycle, starting 1 cycle after the stop sample; no pulses.
REQ-035 rxd low for 5 cycles then high (glitch) -> no push, FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-036 Send 0x55 with the stop bit held low for 20 bit-times -> one frame_error pulse, FIFO empty, no reception until rxd returns high; then 0x01 is received.
REQ-037 FIFO_DEPTH=16, RTS_MARGIN=4, rx_ready=0, send 0x00..0x10 -> rts_n=1 after the 12th byte, 16 bytes stored, overrun pulse on the 17th; draining yields 0x00..0x0F in order.
REQ-038 FIFO full with rx_ready=1 on the stop-sample cycle of a 17th byte 0x77 -> no overrun, count stays 16, 0x77 becomes the last entry.
REQ-039 Assert reset during bit 4 of a frame with 3 bytes buffered -> FIFO empty, rts_n=1 during reset then 0, no frame_error and no overrun pulse.
